register_file: RTL
==================

Name: register_file

Overview:
- Architectural register file with rename tags, one stage downstream of the reorder buffer's commit port and beside the decoder's operand fetch.
- Holds 32 x 32-bit integer registers. Each register carries a busy bit and the ROB id of its youngest in-flight producer.
- Accepts commit writes and dependency (rename) updates from the ROB.
- Resolves two source operands per cycle for the decoder, by direct read, commit bypass or ROB forwarding query.

Parameters:
- ROB_ID_W, 3, width of a ROB entry id (rename tag).
- XLEN, 32, register data width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rdy  in  1  global enable; when low, all state holds.
- clear  in  1  ROB flush request, qualified by rdy.
- need_set_reg_value  in  1  commit write strobe from ROB.
- set_reg_id  in  5  commit destination register.
- set_reg_val  in  XLEN  commit value.
- set_reg_rob_id  in  ROB_ID_W  ROB id of the committing entry.
- need_set_reg_dep  in  1  rename strobe from ROB (new instruction with rd).
- set_dep_reg  in  5  renamed register.
- set_dep_rob_id  in  ROB_ID_W  new producer tag.
- rs1_id  in  5  decoder source 1 index.
- rs2_id  in  5  decoder source 2 index.
- need_rob_id1  out  ROB_ID_W  tag queried in ROB for source 1.
- need_rob_id2  out  ROB_ID_W  tag queried in ROB for source 2.
- rob_value1_ready  in  1  ROB reports tag 1 result available.
- rob_value1  in  XLEN  ROB value for tag 1.
- rob_value2_ready  in  1  ROB reports tag 2 result available.
- rob_value2  in  XLEN  ROB value for tag 2.
- rs1_ready  out  1  source 1 value valid.
- rs1_val  out  XLEN  source 1 value (0 when not ready).
- rs1_dep  out  ROB_ID_W  source 1 producer tag (0 when ready).
- rs2_ready  out  1  source 2 value valid.
- rs2_val  out  XLEN  source 2 value (0 when not ready).
- rs2_dep  out  ROB_ID_W  source 2 producer tag (0 when ready).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All regs = 0, all busy = 0, all tags = 0.
  - Combinational outputs follow: rs*_ready = 1, rs*_val = 0, rs*_dep = 0, need_rob_id* = 0.
- Sequential updates occur only on a clk rising edge with rdy = 1.
- Commit (need_set_reg_value):
  - reg[set_reg_id] <= set_reg_val.
  - busy[set_reg_id] is cleared only if busy = 1 and tag == set_reg_rob_id. On a tag mismatch a younger producer exists: the value is written and busy/tag are kept.
- Rename (need_set_reg_dep): busy[set_dep_reg] <= 1, tag <= set_dep_rob_id.
- Same cycle, same register, commit + rename: value written, rename wins (busy = 1, new tag).
- Writes or renames targeting x0 are ignored; x0 always reads 0 and ready.
- Flush (clear with rdy):
  - All busy bits and tags cleared; register values retained.
  - A commit in the same cycle still writes its value.
  - A rename in the same cycle is discarded.
- Operand read (combinational, zero latency), per source n:
  - Reads use the pre-edge state, so a same-cycle rename of rd never affects the same instruction's sources.
  - need_rob_idn = tag[rsn_id] always.
  - Priority:
    1. rsn_id == 0 -> ready, value 0.
    2. !busy -> ready, reg value.
    3. Commit this cycle with set_reg_id == rsn_id and set_reg_rob_id == tag -> ready, set_reg_val (bypass).
    4. rob_valuen_ready -> ready, rob_valuen.
    5. Otherwise not ready, rsn_dep = tag.
- rdy low: no state change; combinational outputs remain valid from held state.
- Reset asserted mid-operation overrides all pending commit/rename/flush immediately.

Test Plan:
- Reset, then read rs1 = 5, rs2 = 0 -> both ready, values 0, deps 0.
- Rename x5 tag 3; next cycle read x5 with rob_value1_ready = 0 -> rs1_ready = 0, rs1_dep = 3, need_rob_id1 = 3. Raise rob_value1_ready with value 0xDEADBEEF -> ready, value 0xDEADBEEF.
- x5 busy tag 3; commit x5 = 0x1234 tag 3 while reading x5 -> same-cycle bypass ready 0x1234. Next cycle -> busy clear, value 0x1234.
- x5 renamed tag 3 then tag 5; commit x5 tag 3 value 0x11 -> value 0x11 stored, x5 stays busy with tag 5.
- Same cycle commit x7 tag 1 value 0x22 and rename x7 tag 2 -> next read: not ready, dep 2; after a tag 2 commit of 0x33, ready 0x33.
- x3, x4 busy; assert clear with a rename of x6 and a commit of x3 = 0x9 -> all regs ready, x3 = 0x9, x6 not busy. Repeat with rdy = 0 -> no change. Pulse rst_n low mid-stream -> all zero immediately.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with per-register rename tags; resolves two
// source operands per cycle via direct read, commit bypass or ROB forwarding.
module register_file #(
  parameter int unsigned ROB_ID_W = 3,
  parameter int unsigned XLEN     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                clear,
  input  logic                need_set_reg_value,
  input  logic [4:0]          set_reg_id,
  input  logic [XLEN-1:0]     set_reg_val,
  input  logic [ROB_ID_W-1:0] set_reg_rob_id,
  input  logic                need_set_reg_dep,
  input  logic [4:0]          set_dep_reg,
  input  logic [ROB_ID_W-1:0] set_dep_rob_id,
  input  logic [4:0]          rs1_id,
  input  logic [4:0]          rs2_id,
  output logic [ROB_ID_W-1:0] need_rob_id1,
  output logic [ROB_ID_W-1:0] need_rob_id2,
  input  logic                rob_value1_ready,
  input  logic [XLEN-1:0]     rob_value1,
  input  logic                rob_value2_ready,
  input  logic [XLEN-1:0]     rob_value2,
  output logic                rs1_ready,
  output logic [XLEN-1:0]     rs1_val,
  output logic [ROB_ID_W-1:0] rs1_dep,
  output logic                rs2_ready,
  output logic [XLEN-1:0]     rs2_val,
  output logic [ROB_ID_W-1:0] rs2_dep
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned RES_W = 1 + XLEN + ROB_ID_W;

  logic [XLEN-1:0]     regs_q [NREG];
  logic [XLEN-1:0]     regs_d [NREG];
  logic [NREG-1:0]     busy_q;
  logic [NREG-1:0]     busy_d;
  logic [ROB_ID_W-1:0] tag_q  [NREG];
  logic [ROB_ID_W-1:0] tag_d  [NREG];

  logic commit_fire;
  logic rename_fire;

  assign commit_fire = rdy & need_set_reg_value & (set_reg_id != REG_W'(0));
  assign rename_fire = rdy & need_set_reg_dep & (set_dep_reg != REG_W'(0));

  // Next state: commit first, then flush or rename (rename overrides commit's busy clear)
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_fire) begin
      regs_d[set_reg_id] = set_reg_val;
      if (busy_q[set_reg_id] && (tag_q[set_reg_id] == set_reg_rob_id)) begin
        busy_d[set_reg_id] = 1'b0;
      end
    end
    if (rdy && clear) begin
      busy_d = '0;
      for (int i = 0; i < int'(NREG); i++) begin
        tag_d[i] = '0;
      end
    end else if (rename_fire) begin
      busy_d[set_dep_reg] = 1'b1;
      tag_d[set_dep_reg]  = set_dep_rob_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      busy_q <= busy_d;
      regs_q <= regs_d;
      tag_q  <= tag_d;
    end
  end

  // Operand resolution priority: x0, idle register, commit bypass, ROB forward, wait
  function automatic logic [RES_W-1:0] resolve(
    input logic [REG_W-1:0]    id,
    input logic                busy,
    input logic [ROB_ID_W-1:0] tag,
    input logic [XLEN-1:0]     regval,
    input logic                bypass,
    input logic                rob_rdy,
    input logic [XLEN-1:0]     rob_val
  );
    logic                ready;
    logic [XLEN-1:0]     val;
    logic [ROB_ID_W-1:0] dep;
    ready = 1'b1;
    val   = '0;
    dep   = '0;
    if (id == REG_W'(0)) begin
      val = '0;
    end else if (!busy) begin
      val = regval;
    end else if (bypass) begin
      val = set_reg_val;
    end else if (rob_rdy) begin
      val = rob_val;
    end else begin
      ready = 1'b0;
      dep   = tag;
    end
    return {ready, val, dep};
  endfunction

  logic byp1;
  logic byp2;

  assign byp1 = commit_fire & (set_reg_id == rs1_id) & (set_reg_rob_id == tag_q[rs1_id]);
  assign byp2 = commit_fire & (set_reg_id == rs2_id) & (set_reg_rob_id == tag_q[rs2_id]);

  always_comb begin
    {rs1_ready, rs1_val, rs1_dep} = resolve(rs1_id, busy_q[rs1_id], tag_q[rs1_id],
                                            regs_q[rs1_id], byp1, rob_value1_ready, rob_value1);
    {rs2_ready, rs2_val, rs2_dep} = resolve(rs2_id, busy_q[rs2_id], tag_q[rs2_id],
                                            regs_q[rs2_id], byp2, rob_value2_ready, rob_value2);
  end

  assign need_rob_id1 = tag_q[rs1_id];
  assign need_rob_id2 = tag_q[rs2_id];

endmodule
